osd_hexbin_writer: RTL and testbench
====================================

Name: osd_hexbin_writer

Overview:
Downstream consumer of the OSD command batch enqueuer. Accepts one decoded HEX or BIN command per handshake and renders it as ASCII characters. Characters are emitted one per handshake to the OSD text-RAM write port at consecutive addresses starting at base_addr. Other command types are accepted and dropped, so the enqueuer never stalls on them.

Parameters:
WIDTH, 32, bit width of value. Must be a multiple of 4, 4..64.
NIB, WIDTH/4, derived (localparam). Maximum hex digit count.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_type  in  3  osd_cmd_pkg command code (CMD_HEX, CMD_BIN handled)
base_addr  in  16  text-RAM address of first character
value  in  WIDTH  unsigned value to render
hex_prefix_0x  in  1  emit "0x" before hex digits
hex_uppercase  in  1  digits A-F (1) or a-f (0)
hex_min_nibbles  in  8  minimum hex digit count, zero-padded
bin_prefix_0b  in  1  emit "0b" before binary digits
bin_group4  in  1  insert '_' every 4 bits, counted from LSB
wr_valid  out  1  character write offered
wr_ready  in  1  write accepted when wr_valid && wr_ready
wr_addr  out  16  text-RAM address
wr_data  out  8  ASCII character
busy  out  1  command in progress
done  out  1  one-cycle pulse after the last character is accepted
dropped  out  1  one-cycle pulse when a non-HEX/BIN command is accepted

Behaviour:
- Reset (async, any state): state=S_IDLE. cmd_ready=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, dropped=0. A command in progress is abandoned; no further writes.
- cmd_ready=1 only in S_IDLE. Operands are latched on the accept edge; inputs are don't-care afterwards.
- States:
  - S_IDLE. On accept of HEX or BIN: busy=1, go to S_PFX0 if the relevant prefix bit is set, else S_DIG. On accept of any other type: dropped=1 next cycle, stay in S_IDLE.
  - S_PFX0 emits '0'. S_PFX1 emits 'x' (hex) or 'b' (bin), always lowercase.
  - S_DIG emits digits MSB-first.
  - S_SEP emits '_'.
  - S_FIN: done=1, busy=0, back to S_IDLE.
- Digit count:
  - HEX: sig = max(1, index of the highest nonzero nibble + 1). digits = max(sig, min(hex_min_nibbles, NIB)).
  - BIN: digits = max(1, index of the highest set bit + 1). There is no minimum width.
  - value=0 renders a single '0'.
- Group separators (BIN with bin_group4=1): after emitting bit k, emit '_' when k>0 and k%4==0.
- Hex digit mapping: 0-9 → 0x30-0x39. 10-15 → 0x41-0x46 (uppercase) or 0x61-0x66 (lowercase).
- Write timing:
  - First wr_valid is asserted the cycle after command accept.
  - wr_valid stays high and wr_addr/wr_data stay stable until wr_ready.
  - On accept, the next character is presented in the following cycle. There are no bubbles while wr_ready=1, so throughput is 1 char/cycle.
- Addressing: wr_addr = base_addr + character index, modulo 2^16 (wraps 0xFFFF→0x0000).
- Timing of done and the next command: done pulses the cycle after the last write is accepted. cmd_ready returns high in that same cycle, so back-to-back commands cost 1 idle cycle.
- Maximum output: 2 + 64 + 15 = 81 characters. The character counter is 7 bits.

Optional Feature:
OSD_HEXBIN_TERM_EN
- Defined: after the last digit, one extra write of 0x00 at the next address. done follows acceptance of that terminator.
- Undefined: no terminator; done follows the last digit.

Test Plan:
1. HEX value=0x2D, min=4, prefix=1, upper=1, base=0x0100 → writes "0x002D" at 0x0100..0x0105, then done pulse.
2. HEX value=0xBEEF, min=0, prefix=0, upper=0 → "beef". Also value=0, min=0 → single "0".
3. HEX value=0xFF, min=20, WIDTH=32 → clamped to "000000FF" (8 chars).
4. BIN value=0x2D, prefix=1, group4=1, base=0xFFFE → "0b10_1101". Addresses 0xFFFE, 0xFFFF, then wrap to 0x0000..0x0006.
5. Backpressure: wr_ready held low 3 cycles mid-string → wr_addr/wr_data stable across the stall, no characters lost or duplicated. A cmd_type other than HEX/BIN → dropped pulse, zero writes.
6. Assert rst after the 2nd character is accepted → wr_valid=0, busy=0 immediately. A next command starts cleanly at its own base_addr.

Source files
------------

// File: rtl/osd_hexbin_writer.sv
// Renders one HEX or BIN command as ASCII characters written to the OSD text RAM.
// Define OSD_HEXBIN_TERM_EN to append a 0x00 terminator after the last digit.
module osd_hexbin_writer #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] CMD_HEX = 3'd2,
  parameter logic [2:0] CMD_BIN = 3'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_type,
  input  logic [15:0]      base_addr,
  input  logic [WIDTH-1:0] value,
  input  logic             hex_prefix_0x,
  input  logic             hex_uppercase,
  input  logic [7:0]       hex_min_nibbles,
  input  logic             bin_prefix_0b,
  input  logic             bin_group4,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [15:0]      wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             dropped
);
  localparam int NIB = WIDTH / 4;

  typedef enum logic [2:0] {
    S_IDLE, S_PFX0, S_PFX1, S_DIG, S_SEP, S_TERM, S_FIN
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] value_reg;
  logic             is_hex_reg, pfx_reg, upper_reg, group_reg, dropped_reg;
  logic [15:0]      base_reg;
  logic [6:0]       idx_reg, pos_reg;

  logic             accept, is_hex_in, is_bin_in;
  logic [6:0]       hex_sig, bin_sig, hex_min_clamped, hex_digits;
  logic [WIDTH-1:0] dig_shift;
  logic [7:0]       hex_char;

  assign accept    = cmd_valid && cmd_ready;
  assign is_hex_in = (cmd_type == CMD_HEX);
  assign is_bin_in = (cmd_type == CMD_BIN);
  assign dropped   = dropped_reg;

  // Significant digit counts of the incoming value, evaluated at accept time.
  always_comb begin
    hex_sig = 7'd1;
    bin_sig = 7'd1;
    for (int i = 0; i < NIB; i++)
      if (value[4*i +: 4] != 4'd0) hex_sig = 7'(i + 1);
    for (int i = 0; i < WIDTH; i++)
      if (value[i]) bin_sig = 7'(i + 1);
    hex_min_clamped = (hex_min_nibbles > 8'(NIB)) ? 7'(NIB) : hex_min_nibbles[6:0];
    hex_digits      = (hex_min_clamped > hex_sig) ? hex_min_clamped : hex_sig;
  end

  assign dig_shift = is_hex_reg ? (value_reg >> {pos_reg, 2'b00}) : (value_reg >> pos_reg);

  always_comb begin
    if (dig_shift[3:0] < 4'd10)
      hex_char = 8'h30 + {4'd0, dig_shift[3:0]};
    else
      hex_char = (upper_reg ? 8'h37 : 8'h57) + {4'd0, dig_shift[3:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      value_reg   <= '0;
      is_hex_reg  <= 1'b0;
      pfx_reg     <= 1'b0;
      upper_reg   <= 1'b0;
      group_reg   <= 1'b0;
      base_reg    <= '0;
      idx_reg     <= '0;
      pos_reg     <= '0;
      dropped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dropped_reg <= accept && !(is_hex_in || is_bin_in);
      if (accept && (is_hex_in || is_bin_in)) begin
        value_reg  <= value;
        is_hex_reg <= is_hex_in;
        pfx_reg    <= is_hex_in ? hex_prefix_0x : bin_prefix_0b;
        upper_reg  <= hex_uppercase;
        group_reg  <= bin_group4;
        base_reg   <= base_addr;
        idx_reg    <= '0;
        pos_reg    <= (is_hex_in ? hex_digits : bin_sig) - 7'd1;
      end else if (wr_valid && wr_ready) begin
        idx_reg <= idx_reg + 7'd1;
        if (state_reg == S_DIG && pos_reg != 7'd0) pos_reg <= pos_reg - 7'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    done       = 1'b0;
    case (state_reg)
      S_IDLE, S_FIN: begin
        // The done cycle doubles as an idle cycle so back-to-back commands lose only one slot.
        cmd_ready  = 1'b1;
        done       = (state_reg == S_FIN);
        state_next = S_IDLE;
        if (accept && (is_hex_in || is_bin_in))
          state_next = (is_hex_in ? hex_prefix_0x : bin_prefix_0b) ? S_PFX0 : S_DIG;
      end
      S_PFX0: begin
        wr_valid = 1'b1;
        wr_data  = 8'h30;
        if (wr_ready) state_next = S_PFX1;
      end
      S_PFX1: begin
        wr_valid = 1'b1;
        wr_data  = is_hex_reg ? 8'h78 : 8'h62;
        if (wr_ready) state_next = S_DIG;
      end
      S_DIG: begin
        wr_valid = 1'b1;
        wr_data  = is_hex_reg ? hex_char : (dig_shift[0] ? 8'h31 : 8'h30);
        if (wr_ready) begin
          if (pos_reg == 7'd0)
`ifdef OSD_HEXBIN_TERM_EN
            state_next = S_TERM;
`else
            state_next = S_FIN;
`endif
          else if (!is_hex_reg && group_reg && pos_reg[1:0] == 2'b00)
            state_next = S_SEP;
        end
      end
      S_SEP: begin
        wr_valid = 1'b1;
        wr_data  = 8'h5F;
        if (wr_ready) state_next = S_DIG;
      end
      S_TERM: begin
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        if (wr_ready) state_next = S_FIN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy    = wr_valid;
  assign wr_addr = wr_valid ? (base_reg + {9'd0, idx_reg}) : 16'h0000;

endmodule

// File: tb/tb_osd_hexbin_writer.sv
// Scoreboard bench for osd_hexbin_writer: a string-level model queues expected writes,
// a monitor pops and compares every accepted write.
module tb_osd_hexbin_writer;
  localparam int         WIDTH   = 32;
  localparam int         NIB     = WIDTH / 4;
  localparam logic [2:0] CMD_HEX = 3'd2;
  localparam logic [2:0] CMD_BIN = 3'd3;

  logic             clk, rst, cmd_valid, cmd_ready;
  logic [2:0]       cmd_type;
  logic [15:0]      base_addr;
  logic [WIDTH-1:0] value;
  logic             hex_prefix_0x, hex_uppercase, bin_prefix_0b, bin_group4;
  logic [7:0]       hex_min_nibbles;
  logic             wr_valid, wr_ready, busy, done, dropped;
  logic [15:0]      wr_addr;
  logic [7:0]       wr_data;

  osd_hexbin_writer #(.WIDTH(WIDTH), .CMD_HEX(CMD_HEX), .CMD_BIN(CMD_BIN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .base_addr(base_addr), .value(value),
    .hex_prefix_0x(hex_prefix_0x), .hex_uppercase(hex_uppercase),
    .hex_min_nibbles(hex_min_nibbles), .bin_prefix_0b(bin_prefix_0b),
    .bin_group4(bin_group4), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0, errors = 0;
  int          acc_cnt = 0, done_cnt = 0, drop_cnt = 0, exp_done = 0, exp_drop = 0;
  bit          rand_rdy = 0, stall_win = 0;
  logic [15:0] m_addr;

  // Sink: either random backpressure or always-ready with an optional stall window.
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) wr_ready = ($urandom_range(0, 3) != 0);
      else          wr_ready = !stall_win;
    end
  end

  // Monitor
  initial begin
    logic        stalled;
    logic [15:0] st_addr;
    logic [7:0]  st_data;
    wr_t         e;
    stalled = 1'b0;
    st_addr = '0;
    st_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (!wr_valid || wr_addr != st_addr || wr_data != st_data) begin
            errors++;
            $display("FAIL stall_hold got v=%0b addr=%h data=%h want v=1 addr=%h data=%h",
                     wr_valid, wr_addr, wr_data, st_addr, st_data);
          end
        end
        if (wr_valid && wr_ready) begin
          acc_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got addr=%h data=%h want none", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            if (wr_addr != e.addr || wr_data != e.data) begin
              errors++;
              $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                       wr_addr, wr_data, e.addr, e.data);
            end else begin
              $display("WR addr=%h data=%h", wr_addr, wr_data);
            end
          end
        end
        stalled = wr_valid && !wr_ready;
        st_addr = wr_addr;
        st_data = wr_data;
        if (done) begin
          done_cnt++;
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_early got pending=%0d want 0", exp_q.size());
          end
        end
        if (dropped) drop_cnt++;
      end
    end
  end

  function automatic void push_ch(input logic [7:0] c);
    wr_t w;
    w.addr = m_addr;
    w.data = c;
    exp_q.push_back(w);
    m_addr = m_addr + 16'd1;
  endfunction

  // Reference rendering straight from the textual rules.
  function automatic void model(input bit is_hex, input logic [31:0] v, input logic [15:0] base,
                                input bit pfx, input bit upper, input int minn, input bit grp);
    logic [31:0] t;
    int          cnt, d;
    m_addr = base;
    t = v;
    cnt = 0;
    if (pfx) begin
      push_ch(8'h30);
      push_ch(is_hex ? 8'h78 : 8'h62);
    end
    if (is_hex) begin
      while (t != 0) begin cnt++; t = t >> 4; end
      if (cnt == 0) cnt = 1;
      if (minn > NIB) minn = NIB;
      if (minn > cnt) cnt = minn;
      for (int i = cnt - 1; i >= 0; i--) begin
        d = int'((v >> (4 * i)) & 32'hF);
        if (d < 10) push_ch(8'(48 + d));
        else        push_ch(8'((upper ? 65 : 97) + d - 10));
      end
    end else begin
      while (t != 0) begin cnt++; t = t >> 1; end
      if (cnt == 0) cnt = 1;
      for (int i = cnt - 1; i >= 0; i--) begin
        push_ch(v[i] ? 8'h31 : 8'h30);
        if (grp && i > 0 && i % 4 == 0) push_ch(8'h5F);
      end
    end
`ifdef OSD_HEXBIN_TERM_EN
    push_ch(8'h00);
`endif
    exp_done++;
  endfunction

  task automatic send_cmd(input logic [2:0] t, input logic [15:0] base, input logic [31:0] v,
                          input bit hp, input bit hu, input logic [7:0] hm,
                          input bit bp, input bit bg);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout got ready=0 want 1");
      return;
    end
    cmd_type = t; base_addr = base; value = v;
    hex_prefix_0x = hp; hex_uppercase = hu; hex_min_nibbles = hm;
    bin_prefix_0b = bp; bin_group4 = bg;
    cmd_valid = 1'b1;
    $display("CMD type=%0d base=%h value=%h hp=%0b hu=%0b hm=%0d bp=%0b bg=%0b",
             t, base, v, hp, hu, hm, bp, bg);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (t == CMD_HEX)      model(1'b1, v, base, hp, hu, int'(hm), 1'b0);
    else if (t == CMD_BIN) model(1'b0, v, base, bp, 1'b0, 0, bg);
    else                   exp_drop++;
    // Scramble operands: the DUT must have latched them already.
    value = $urandom; base_addr = 16'($urandom); hex_min_nibbles = 8'($urandom);
    hex_uppercase = ~hu; bin_group4 = ~bg;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout got pending=%0d busy=%0b want 0 0", exp_q.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int start;
    logic [2:0] t;
    int sel;
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; base_addr = '0; value = '0;
    hex_prefix_0x = 0; hex_uppercase = 0; hex_min_nibbles = '0; bin_prefix_0b = 0; bin_group4 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        dropped !== 1'b0 || wr_addr !== 16'h0 || wr_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b v=%0b busy=%0b done=%0b drop=%0b addr=%h data=%h want 1 0 0 0 0 0000 00",
               cmd_ready, wr_valid, busy, done, dropped, wr_addr, wr_data);
    end
    @(posedge clk); #2 rst = 1'b0;

    send_cmd(CMD_HEX, 16'h0100, 32'h2D, 1, 1, 8'd4, 0, 0);       wait_quiet();
    send_cmd(CMD_HEX, 16'h0010, 32'hBEEF, 0, 0, 8'd0, 0, 0);     wait_quiet();
    send_cmd(CMD_HEX, 16'h0020, 32'h0, 0, 0, 8'd0, 0, 0);        wait_quiet();
    send_cmd(CMD_HEX, 16'h0030, 32'hFF, 0, 1, 8'd20, 0, 0);      wait_quiet();
    send_cmd(CMD_BIN, 16'hFFFE, 32'h2D, 0, 0, 8'd0, 1, 1);       wait_quiet();
    send_cmd(CMD_BIN, 16'h0040, 32'h0, 0, 0, 8'd0, 0, 1);        wait_quiet();
    send_cmd(CMD_BIN, 16'h0050, 32'hFFFFFFFF, 0, 0, 8'd0, 1, 1); wait_quiet();

    // Mid-string stall of three cycles
    start = acc_cnt;
    send_cmd(CMD_HEX, 16'h0200, 32'h12345678, 1, 1, 8'd0, 0, 0);
    while (acc_cnt < start + 3) @(negedge clk);
    stall_win = 1'b1;
    repeat (3) @(negedge clk);
    stall_win = 1'b0;
    wait_quiet();
    send_cmd(3'd0, 16'h0300, 32'h1234, 1, 1, 8'd0, 1, 1);        wait_quiet();

    // Reset in the middle of a command
    start = acc_cnt;
    send_cmd(CMD_HEX, 16'h0300, 32'hABCDEF, 1, 0, 8'd0, 0, 0);
    while (acc_cnt < start + 2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got v=%0b busy=%0b want 0 0", wr_valid, busy);
    end
    exp_q.delete();
    exp_done--;
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;
    send_cmd(CMD_HEX, 16'h0400, 32'hC0DE, 1, 1, 8'd6, 0, 0);     wait_quiet();

    // Randomized traffic with random backpressure, commands back to back
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 4);
      if (sel < 2)      t = CMD_HEX;
      else if (sel < 4) t = CMD_BIN;
      else begin
        t = 3'($urandom_range(0, 7));
        if (t == CMD_HEX || t == CMD_BIN) t = 3'd7;
      end
      send_cmd(t, 16'($urandom), $urandom >> $urandom_range(0, 31), 1'($urandom),
               1'($urandom), 8'($urandom_range(0, 12)), 1'($urandom), 1'($urandom));
    end
    wait_quiet();

    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", done_cnt, exp_done);
    end
    checks++;
    if (drop_cnt != exp_drop) begin
      errors++;
      $display("FAIL drop_count got %0d want %0d", drop_cnt, exp_drop);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
